// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// ============================================================================
// mem_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Two-requester arbiter and sequencer for the single-port data memory of
//   the single-cycle RISC-V core. Port 0 is the core load/store path, port 1
//   is the program loader / debug path. One request is accepted at a time,
//   strobed onto the memory port for one cycle, and after MEM_LAT cycles a
//   one-cycle completion pulse is returned to the granted requester.
//
//   Sequence:  IDLE (accept) -> ISSUE (m_en) -> WAIT (MEM_LAT cycles) -> RESP
//
// Parameters:
//   ADDR_W   byte-address width
//   DATA_W   data width, multiple of 8
//   MEM_LAT  memory read latency in cycles, 1..4
//
// Configuration macro:
//   ARB_FIXED_PRIORITY_EN  defined   -> port 0 always wins simultaneous requests
//                          undefined -> round-robin on the `last` register
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   rN_valid / rN_ready      request handshake (ready only in IDLE, winner only)
//   rN_we/addr/wdata/wmask   request fields, captured on accept
//   rN_rvalid / rN_rdata     one-cycle completion pulse, read data (0 on writes)
//   m_en/we/addr/wdata/wmask memory strobe and fields, valid during ISSUE only
//   m_rdata                  memory read data, valid MEM_LAT cycles after m_en
//   busy                     high in every state except IDLE
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic                  r0_we,
    input  logic [ADDR_W-1:0]     r0_addr,
    input  logic [DATA_W-1:0]     r0_wdata,
    input  logic [DATA_W/8-1:0]   r0_wmask,
    output logic                  r0_rvalid,
    output logic [DATA_W-1:0]     r0_rdata,

    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic                  r1_we,
    input  logic [ADDR_W-1:0]     r1_addr,
    input  logic [DATA_W-1:0]     r1_wdata,
    input  logic [DATA_W/8-1:0]   r1_wmask,
    output logic                  r1_rvalid,
    output logic [DATA_W-1:0]     r1_rdata,

    output logic                  m_en,
    output logic                  m_we,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wmask,
    input  logic [DATA_W-1:0]     m_rdata,

    output logic                  busy
);

    localparam int MASK_W = DATA_W / 8;
    // Two bits cover the whole legal latency range (counter loads 0..3).
    localparam int CNT_W  = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;
    logic                r_gnt;
    logic                r_last;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    logic                w_gnt;
    logic                w_accept;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [MASK_W-1:0]   w_sel_wmask;
    logic [DATA_W-1:0]   w_resp_data;

    // ------------------------------------------------------------------------
    // Arbitration: pick the winner among the valid requesters.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path through the block can infer a latch.
        w_gnt = 1'b0;
        if (r0_valid && r1_valid) begin
`ifdef ARB_FIXED_PRIORITY_EN
            w_gnt = 1'b0;
`else
            w_gnt = ~r_last;
`endif
        end else if (r1_valid) begin
            w_gnt = 1'b1;
        end
    end

    // Gating with rst keeps ready low while reset is held even though the
    // state is already IDLE.
    assign w_accept    = (r_state == S_IDLE) && !rst && (r0_valid || r1_valid);

    assign w_sel_we    = w_gnt ? r1_we    : r0_we;
    assign w_sel_addr  = w_gnt ? r1_addr  : r0_addr;
    assign w_sel_wdata = w_gnt ? r1_wdata : r0_wdata;
    assign w_sel_wmask = w_gnt ? r1_wmask : r0_wmask;

    // Writes complete with zero data regardless of what the memory returns.
    assign w_resp_data = r_we ? '0 : m_rdata;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers: request capture, latency counter, response data.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wmask  <= '0;
            r_gnt    <= 1'b0;
            r_last   <= 1'b1;
            r_cnt    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_wmask <= w_sel_wmask;
                        r_gnt   <= w_gnt;
                        r_last  <= w_gnt;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= CNT_W'(MEM_LAT - 1);
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        // Only the granted port's data register changes; the
                        // other keeps its last returned value.
                        if (r_gnt) begin
                            r_rdata1 <= w_resp_data;
                        end else begin
                            r_rdata0 <= w_resp_data;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        r0_ready  = w_accept && !w_gnt;
        r1_ready  = w_accept &&  w_gnt;

        m_en      = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_wmask   = '0;

        r0_rvalid = 1'b0;
        r1_rvalid = 1'b0;
        r0_rdata  = r_rdata0;
        r1_rdata  = r_rdata1;

        busy      = (r_state != S_IDLE);

        case (r_state)
            S_ISSUE: begin
                m_en    = 1'b1;
                m_we    = r_we;
                m_addr  = r_addr;
                m_wdata = r_wdata;
                m_wmask = r_we ? r_wmask : '0;
            end
            S_RESP: begin
                r0_rvalid = !r_gnt;
                r1_rvalid =  r_gnt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// ============================================================================
// tb_mem_arbiter
// ----------------------------------------------------------------------------
// Two arbiter instances share clock and reset: g_dut[0] with MEM_LAT=1 and
// g_dut[1] with MEM_LAT=4. Each has a memory model that presents valid read
// data only in the exact cycle MEM_LAT after m_en, and garbage otherwise.
// Stimulus pushes the expected completion (port, data, cycle) into a per-
// instance queue; a monitor pops and compares whenever an rvalid pulses.
// Inputs are driven 1 ns after the rising edge, outputs sampled on the
// falling edge.
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

`ifdef ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic          r0_valid [2];
    logic          r0_ready [2];
    logic          r0_we    [2];
    logic [AW-1:0] r0_addr  [2];
    logic [DW-1:0] r0_wdata [2];
    logic [MW-1:0] r0_wmask [2];
    logic          r0_rvalid[2];
    logic [DW-1:0] r0_rdata [2];
    logic          r1_valid [2];
    logic          r1_ready [2];
    logic          r1_we    [2];
    logic [AW-1:0] r1_addr  [2];
    logic [DW-1:0] r1_wdata [2];
    logic [MW-1:0] r1_wmask [2];
    logic          r1_rvalid[2];
    logic [DW-1:0] r1_rdata [2];
    logic          m_en     [2];
    logic          m_we     [2];
    logic [AW-1:0] m_addr   [2];
    logic [DW-1:0] m_wdata  [2];
    logic [MW-1:0] m_wmask  [2];
    logic [DW-1:0] m_rdata  [2];
    logic          busy     [2];

    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int k, input int port, input logic [31:0] data, input int c);
        exp_t e;
        e.port = port;
        e.data = data;
        e.cyc  = c;
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    // ------------------------------------------------------------------------
    // DUTs and memory models
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 1 : 4;
        logic [31:0] pd[4];
        logic        pv[4];

        mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .r0_valid (r0_valid[k]),
            .r0_ready (r0_ready[k]),
            .r0_we    (r0_we[k]),
            .r0_addr  (r0_addr[k]),
            .r0_wdata (r0_wdata[k]),
            .r0_wmask (r0_wmask[k]),
            .r0_rvalid(r0_rvalid[k]),
            .r0_rdata (r0_rdata[k]),
            .r1_valid (r1_valid[k]),
            .r1_ready (r1_ready[k]),
            .r1_we    (r1_we[k]),
            .r1_addr  (r1_addr[k]),
            .r1_wdata (r1_wdata[k]),
            .r1_wmask (r1_wmask[k]),
            .r1_rvalid(r1_rvalid[k]),
            .r1_rdata (r1_rdata[k]),
            .m_en     (m_en[k]),
            .m_we     (m_we[k]),
            .m_addr   (m_addr[k]),
            .m_wdata  (m_wdata[k]),
            .m_wmask  (m_wmask[k]),
            .m_rdata  (m_rdata[k]),
            .busy     (busy[k])
        );

        always @(posedge clk) begin
            pv[0] <= m_en[k];
            pd[0] <= mem_val(m_addr[k]);
            for (int i = 1; i < 4; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end

        assign m_rdata[k] = pv[LAT-1] ? pd[LAT-1] : 32'hBAD0_BAD0;
    end

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    task automatic mon(input int k);
        exp_t        e;
        bit          have;
        int          port;
        logic [31:0] rd;
        if (r0_rvalid[k] || r1_rvalid[k]) begin
            have = 1'b0;
            if (k == 0) begin
                if (sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
            end else begin
                if (sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
            end
            check($sformatf("i%0d_rvalid_onehot", k),
                  64'(r0_rvalid[k] && r1_rvalid[k]), 64'(0));
            check($sformatf("i%0d_rvalid_expected", k), 64'(have), 64'(1));
            if (have) begin
                port = r1_rvalid[k] ? 1 : 0;
                rd   = r1_rvalid[k] ? r1_rdata[k] : r0_rdata[k];
                check($sformatf("i%0d_rvalid_port", k), 64'(port), 64'(e.port));
                check($sformatf("i%0d_rdata", k), 64'(rd), 64'(e.data));
                check($sformatf("i%0d_rvalid_cycle", k), 64'(cyc), 64'(e.cyc));
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) mon(k);
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic check_zero_outs(input int k, input string tag);
        check($sformatf("i%0d_%s_busy", k, tag),      64'(busy[k]),      64'(0));
        check($sformatf("i%0d_%s_r0_ready", k, tag),  64'(r0_ready[k]),  64'(0));
        check($sformatf("i%0d_%s_r1_ready", k, tag),  64'(r1_ready[k]),  64'(0));
        check($sformatf("i%0d_%s_r0_rvalid", k, tag), 64'(r0_rvalid[k]), 64'(0));
        check($sformatf("i%0d_%s_r1_rvalid", k, tag), 64'(r1_rvalid[k]), 64'(0));
        check($sformatf("i%0d_%s_r0_rdata", k, tag),  64'(r0_rdata[k]),  64'(0));
        check($sformatf("i%0d_%s_r1_rdata", k, tag),  64'(r1_rdata[k]),  64'(0));
        check($sformatf("i%0d_%s_m_en", k, tag),      64'(m_en[k]),      64'(0));
        check($sformatf("i%0d_%s_m_we", k, tag),      64'(m_we[k]),      64'(0));
        check($sformatf("i%0d_%s_m_addr", k, tag),    64'(m_addr[k]),    64'(0));
        check($sformatf("i%0d_%s_m_wdata", k, tag),   64'(m_wdata[k]),   64'(0));
        check($sformatf("i%0d_%s_m_wmask", k, tag),   64'(m_wmask[k]),   64'(0));
    endtask

    // Hard stop in case the run ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int t;
        int s;
        int r;
        bit e0;
        bit e1;
        int p2;

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            // Valids high during reset: ready must still read 0.
            r0_valid[k] = 1'b1; r0_we[k] = 1'b0; r0_addr[k] = '0; r0_wdata[k] = '0; r0_wmask[k] = '0;
            r1_valid[k] = 1'b1; r1_we[k] = 1'b0; r1_addr[k] = '0; r1_wdata[k] = '0; r1_wmask[k] = '0;
        end

        repeat (2) tick();
        smp();
        for (int k = 0; k < 2; k++) check_zero_outs(k, "reset");

        tick();
        for (int k = 0; k < 2; k++) begin
            r0_valid[k] = 1'b0;
            r1_valid[k] = 1'b0;
        end
        rst = 1'b0;
        tick();

        // ---- Test 1: single read on port 0, MEM_LAT=1 --------------------
        t = cyc;
        r0_valid[0] = 1'b1; r0_we[0] = 1'b0; r0_addr[0] = 32'h10; r0_wmask[0] = 4'hF;
        push_exp(0, 0, 32'hDEAD_BEEF, t + 3);
        smp();
        check("t1_r0_ready", 64'(r0_ready[0]), 64'(1));
        check("t1_r1_ready", 64'(r1_ready[0]), 64'(0));
        tick();
        r0_valid[0] = 1'b0;
        smp();
        check("t1_m_en",    64'(m_en[0]),    64'(1));
        check("t1_m_we",    64'(m_we[0]),    64'(0));
        check("t1_m_wmask", 64'(m_wmask[0]), 64'(0));
        check("t1_m_addr",  64'(m_addr[0]),  64'(32'h10));
        check("t1_busy_t1", 64'(busy[0]),    64'(1));
        check("t1_ready_busy", 64'(r0_ready[0]), 64'(0));
        tick(); smp();
        check("t1_m_en_t2", 64'(m_en[0]), 64'(0));
        check("t1_busy_t2", 64'(busy[0]), 64'(1));
        tick(); smp();
        check("t1_busy_t3", 64'(busy[0]), 64'(1));
        tick(); smp();
        check("t1_busy_t4", 64'(busy[0]), 64'(0));
        check("t1_r0_rdata_hold", 64'(r0_rdata[0]), 64'(32'hDEAD_BEEF));

        // ---- Test 2: single write on port 1 ------------------------------
        tick();
        t = cyc;
        r1_valid[0] = 1'b1; r1_we[0] = 1'b1; r1_addr[0] = 32'h20;
        r1_wdata[0] = 32'h1234_5678; r1_wmask[0] = 4'hF;
        push_exp(0, 1, 32'h0, t + 3);
        smp();
        check("t2_r1_ready", 64'(r1_ready[0]), 64'(1));
        check("t2_r0_ready", 64'(r0_ready[0]), 64'(0));
        tick();
        r1_valid[0] = 1'b0; r1_we[0] = 1'b0;
        smp();
        check("t2_m_en",    64'(m_en[0]),    64'(1));
        check("t2_m_we",    64'(m_we[0]),    64'(1));
        check("t2_m_wmask", 64'(m_wmask[0]), 64'(4'hF));
        check("t2_m_wdata", 64'(m_wdata[0]), 64'(32'h1234_5678));
        check("t2_m_addr",  64'(m_addr[0]),  64'(32'h20));
        repeat (3) tick();
        smp();
        check("t2_busy_end",   64'(busy[0]),     64'(0));
        check("t2_r0_rdata_hold", 64'(r0_rdata[0]), 64'(32'hDEAD_BEEF));

        // ---- Test 3: both valid held for three transactions -------------
        tick();
        s = cyc;
        r0_valid[0] = 1'b1; r0_we[0] = 1'b0; r0_addr[0] = 32'h30;
        r1_valid[0] = 1'b1; r1_we[0] = 1'b0; r1_addr[0] = 32'h40;
        p2 = FIXED ? 0 : 1;
        push_exp(0, 0,  mem_val(32'h30), s + 3);
        push_exp(0, p2, (p2 == 1) ? mem_val(32'h40) : mem_val(32'h30), s + 7);
        push_exp(0, 0,  mem_val(32'h30), s + 11);
        for (int c = 0; c <= 8; c++) begin
            smp();
            e0 = (c == 0) || (c == 8) || (FIXED && c == 4);
            e1 = !FIXED && (c == 4);
            check($sformatf("t3_r0_ready_c%0d", c), 64'(r0_ready[0]), 64'(e0));
            check($sformatf("t3_r1_ready_c%0d", c), 64'(r1_ready[0]), 64'(e1));
            if (c < 8) tick();
        end
        tick();
        r0_valid[0] = 1'b0;
        r1_valid[0] = 1'b0;
        repeat (3) tick();
        smp();
        check("t3_busy_end", 64'(busy[0]), 64'(0));

        // ---- Test 4: MEM_LAT=4, second request held during busy ----------
        tick();
        t = cyc;
        r0_valid[1] = 1'b1; r0_we[1] = 1'b0; r0_addr[1] = 32'h50;
        push_exp(1, 0, mem_val(32'h50), t + 6);
        smp();
        check("t4_r0_ready", 64'(r0_ready[1]), 64'(1));
        tick();
        r0_valid[1] = 1'b0;
        r1_valid[1] = 1'b1; r1_we[1] = 1'b0; r1_addr[1] = 32'h60;
        push_exp(1, 1, mem_val(32'h60), t + 13);
        smp();
        check("t4_m_en",   64'(m_en[1]),   64'(1));
        check("t4_m_addr", 64'(m_addr[1]), 64'(32'h50));
        for (int c = 2; c <= 7; c++) begin
            tick(); smp();
            check($sformatf("t4_r1_ready_c%0d", c), 64'(r1_ready[1]), 64'(c == 7));
            check($sformatf("t4_busy_c%0d", c),     64'(busy[1]),     64'(c != 7));
        end
        tick();
        r1_valid[1] = 1'b0;
        repeat (6) tick();
        smp();
        check("t4_busy_end", 64'(busy[1]), 64'(0));

        // ---- Test 5: reset during WAIT ------------------------------------
        // Port 0 is accepted last on instance 1, so without reset a both-valid
        // request would go to port 1.
        tick();
        r0_valid[1] = 1'b1; r0_we[1] = 1'b0; r0_addr[1] = 32'h70;
        smp();
        check("t5_r0_ready", 64'(r0_ready[1]), 64'(1));
        tick();
        r0_valid[1] = 1'b0;
        tick();
        tick();
        smp();
        check("t5_busy_wait", 64'(busy[1]), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            r0_valid[k] = 1'b1; r0_we[k] = 1'b0; r0_addr[k] = 32'h80;
            r1_valid[k] = 1'b1; r1_we[k] = 1'b0; r1_addr[k] = 32'h90;
        end
        #1;
        for (int k = 0; k < 2; k++) check_zero_outs(k, "midrst");
        tick();
        tick();
        rst = 1'b0;
        r = cyc;
        push_exp(0, 0, mem_val(32'h80), r + 3);
        push_exp(1, 0, mem_val(32'h80), r + 6);
        smp();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t5_i%0d_r0_ready_post", k), 64'(r0_ready[k]), 64'(1));
            check($sformatf("t5_i%0d_r1_ready_post", k), 64'(r1_ready[k]), 64'(0));
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            r0_valid[k] = 1'b0;
            r1_valid[k] = 1'b0;
        end
        repeat (6) tick();
        smp();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t5_i%0d_busy_end", k), 64'(busy[k]), 64'(0));
        end

        // ---- Drain: every expected completion must have been seen --------
        repeat (3) tick();
        smp();
        check("sb0_drained", 64'(sb0.size()), 64'(0));
        check("sb1_drained", 64'(sb1.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
